// File: rtl/sd_dat_pkg.sv
// Shared types and constants for the SD DAT-line transfer sequencer.
// Holds the FSM state encoding, the error codes and a saturating counter helper.
package sd_dat_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FIFO,
    XFER,
    BUSY_WAIT,
    CHECK,
    GAP,
    DONE,
    ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CRC  = 2'b01;
  localparam logic [1:0] ERR_TOUT = 2'b10;

  // Block count sticks at all-ones instead of wrapping on very long open-ended runs.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dat_xfer_ctrl_if.sv
// Bundle of register-file, buffer and serializer signals around the DAT transfer sequencer.
// The sequencer connects through the slave modport; the surrounding logic uses master.
interface dat_xfer_ctrl_if #(
  parameter int TOUT_W = 16
);
  import sd_dat_pkg::*;

  logic              trans_enable;
  logic              mode;
  logic              dat_width;
  logic              direction;
  logic [11:0]       block_size;
  logic [15:0]       block_num;
  logic [TOUT_W-1:0] timeout_val;
  logic              abort;
  logic              fifo_ready;
  logic              phy_done;
  logic              phy_crc_ok;
  logic              card_busy;

  logic              phy_start;
  logic              phy_dir;
  logic              phy_width;
  logic [11:0]       phy_bytes;
  logic              busy;
  logic [15:0]       blocks_done;
  logic              finnished_trans;
  logic              trans_error;
  logic [1:0]        err_code;
  state_t            dbg_state;

  // Handshake: fifo_ready is the block-level ready; a block is started (phy_start, one-cycle
  // valid strobe) only after fifo_ready is seen high in WAIT_FIFO. phy_done is a one-cycle
  // completion strobe and phy_crc_ok is meaningful only in the cycle phy_done is high.
  modport master (
    output trans_enable, mode, dat_width, direction, block_size, block_num, timeout_val,
           abort, fifo_ready, phy_done, phy_crc_ok, card_busy,
    input  phy_start, phy_dir, phy_width, phy_bytes, busy, blocks_done,
           finnished_trans, trans_error, err_code, dbg_state
  );

  modport slave (
    input  trans_enable, mode, dat_width, direction, block_size, block_num, timeout_val,
           abort, fifo_ready, phy_done, phy_crc_ok, card_busy,
    output phy_start, phy_dir, phy_width, phy_bytes, busy, blocks_done,
           finnished_trans, trans_error, err_code, dbg_state
  );

endinterface

// File: rtl/dat_timeout_cnt.sv
// Cycle counter that flags expiry when it reaches a nonzero limit; a zero limit disables it.
// The count freezes at expiry (and at all-ones) so it never wraps back into range.
module dat_timeout_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] cnt;

  assign expired = (limit != '0) && (cnt == limit);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable && !expired && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dat_xfer_ctrl.sv
// SD host DAT-line block transfer sequencer: gates each block on buffer readiness, waits out
// card busy on writes, enforces inter-block gaps and timeouts, and reports done/error.
module dat_xfer_ctrl
  import sd_dat_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int TOUT_W     = 16
) (
  input logic           clk,
  input logic           reset,
  dat_xfer_ctrl_if.slave bus
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t            state;
  logic [GAP_W-1:0]  gap_cnt;
  logic [15:0]       target;
  logic [15:0]       blocks_done;
  logic [TOUT_W-1:0] tout_lim;
  logic              dir_q;
  logic              width_q;
  logic [11:0]       bytes_q;
  logic              phy_start_q;
  logic              fin_q;
  logic              err_q;
  logic [1:0]        err_code_q;

  logic tout_en;
  logic tout_clear;
  logic tout_expired;

  // The timer runs only in XFER/BUSY_WAIT and restarts on the XFER -> BUSY_WAIT hand-over.
  assign tout_en    = (state == XFER) || (state == BUSY_WAIT);
  assign tout_clear = !tout_en || ((state == XFER) && bus.phy_done);

  dat_timeout_cnt #(.W(TOUT_W)) u_tout (
    .clk     (clk),
    .reset   (reset),
    .clear   (tout_clear),
    .enable  (tout_en),
    .limit   (tout_lim),
    .expired (tout_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      target      <= '0;
      blocks_done <= '0;
      tout_lim    <= '0;
      dir_q       <= 1'b0;
      width_q     <= 1'b0;
      bytes_q     <= '0;
      phy_start_q <= 1'b0;
      fin_q       <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      phy_start_q <= 1'b0;
      fin_q       <= 1'b0;
      err_q       <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.trans_enable) begin
            target      <= bus.mode ? bus.block_num : 16'd1;
            tout_lim    <= bus.timeout_val;
            dir_q       <= bus.direction;
            width_q     <= bus.dat_width;
            bytes_q     <= bus.block_size;
            blocks_done <= '0;
            err_code_q  <= ERR_NONE;
            state       <= WAIT_FIFO;
          end
        end
        WAIT_FIFO: begin
          if (bus.abort) begin
            fin_q <= 1'b1;
            state <= DONE;
          end else if (bus.fifo_ready) begin
            phy_start_q <= 1'b1;
            state       <= XFER;
          end
        end
        XFER: begin
          // A completion landing on the expiry cycle still counts as a good block.
          if (bus.phy_done) begin
            if (bus.phy_crc_ok) begin
              blocks_done <= sat_inc16(blocks_done);
              state       <= dir_q ? BUSY_WAIT : CHECK;
            end else begin
              err_code_q <= ERR_CRC;
              err_q      <= 1'b1;
              state      <= ERROR;
            end
          end else if (tout_expired) begin
            err_code_q <= ERR_TOUT;
            err_q      <= 1'b1;
            state      <= ERROR;
          end
        end
        BUSY_WAIT: begin
          if (!bus.card_busy) begin
            state <= CHECK;
          end else if (tout_expired) begin
            err_code_q <= ERR_TOUT;
            err_q      <= 1'b1;
            state      <= ERROR;
          end
        end
        CHECK: begin
          if (bus.abort || ((target != 16'd0) && (blocks_done == target))) begin
            fin_q <= 1'b1;
            state <= DONE;
          end else if (GAP_CYCLES == 0) begin
            state <= WAIT_FIFO;
          end else begin
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (bus.abort) begin
            fin_q <= 1'b1;
            state <= DONE;
          end else if (gap_cnt == GAP_LAST) begin
            state <= WAIT_FIFO;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        ERROR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.phy_start       = phy_start_q;
  assign bus.phy_dir         = dir_q;
  assign bus.phy_width       = width_q;
  assign bus.phy_bytes       = bytes_q;
  assign bus.busy            = (state != IDLE);
  assign bus.blocks_done     = blocks_done;
  assign bus.finnished_trans = fin_q;
  assign bus.trans_error     = err_q;
  assign bus.err_code        = err_code_q;
  assign bus.dbg_state       = state;

endmodule
